// File: rtl/trace_pkt_fifo.sv
// Retire-trace buffer: compacts up to LANES retired-instruction records per cycle
// into a DEPTH-entry FIFO and drains one record per cycle over valid/ready.
module trace_pkt_fifo #(
  parameter int LANES = 3,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [LANES-1:0]         in_valid,
  input  logic [32*LANES-1:0]      in_insn,
  input  logic [32*LANES-1:0]      in_addr,
  input  logic [LANES-1:0]         in_exception,
  input  logic [LANES-1:0]         in_interrupt,
  input  logic [4:0]               in_ecause,
  input  logic [31:0]              in_tval,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_insn,
  output logic [31:0]              out_addr,
  output logic                     out_exception,
  output logic                     out_interrupt,
  output logic [4:0]               out_ecause,
  output logic [31:0]              out_tval,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_status
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int PW1 = PW + 1;
  localparam int NW  = $clog2(LANES + 1);
  localparam int SW  = CNT_W + NW;

  logic [31:0] mem_insn   [DEPTH];
  logic [31:0] mem_addr   [DEPTH];
  logic        mem_exc    [DEPTH];
  logic        mem_int    [DEPTH];
  logic [4:0]  mem_ecause [DEPTH];
  logic [31:0] mem_tval   [DEPTH];

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [NW-1:0]  n_valid;
  logic [AW-1:0]  lane_idx [LANES];
  logic           fits;
  logic           push_en;
  logic           drop;
  logic           pop;
  logic [CNT_W-1:0] cnt_base;
  logic [SW-1:0]    cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it,
  // so holes in in_valid are squeezed out while lane order is kept.
  always_comb begin
    n_valid = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_idx[i] = wr_ptr[AW-1:0] + AW'(n_valid);
      n_valid     = n_valid + NW'(in_valid[i]);
    end
  end

  assign level     = wr_ptr - rd_ptr;
  assign out_valid = (wr_ptr != rd_ptr);

  // Room is judged against the pre-pop level; a group is all-or-nothing.
  assign fits    = ({1'b0, level} + PW1'(n_valid)) <= PW1'(DEPTH);
  assign push_en = !flush && fits && (n_valid != '0);
  assign drop    = !flush && !fits;
  assign pop     = !flush && out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(n_valid);
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (in_valid[i]) begin
          mem_insn[lane_idx[i]]   <= in_insn[32*i +: 32];
          mem_addr[lane_idx[i]]   <= in_addr[32*i +: 32];
          mem_exc[lane_idx[i]]    <= in_exception[i];
          mem_int[lane_idx[i]]    <= in_interrupt[i];
          mem_ecause[lane_idx[i]] <= (in_exception[i] || in_interrupt[i]) ? in_ecause : '0;
          mem_tval[lane_idx[i]]   <= (in_exception[i] || in_interrupt[i]) ? in_tval : '0;
        end
      end
    end
  end

  assign out_insn      = mem_insn[rd_ptr[AW-1:0]];
  assign out_addr      = mem_addr[rd_ptr[AW-1:0]];
  assign out_exception = mem_exc[rd_ptr[AW-1:0]];
  assign out_interrupt = mem_int[rd_ptr[AW-1:0]];
  assign out_ecause    = mem_ecause[rd_ptr[AW-1:0]];
  assign out_tval      = mem_tval[rd_ptr[AW-1:0]];

  // A same-cycle clear zeroes the base first, so a concurrent drop leaves drop_cnt = n.
  always_comb begin
    cnt_base = clr_status ? '0 : drop_cnt;
    cnt_sum  = SW'(cnt_base) + SW'(n_valid);
    cnt_next = (cnt_sum > SW'({CNT_W{1'b1}})) ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= cnt_next;
    end else if (clr_status) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_trace_pkt_fifo.sv
// Bench for trace_pkt_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_trace_pkt_fifo;
  localparam int LANES = 3;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, flush, out_ready, clr_status;
  logic [LANES-1:0] in_valid, in_exception, in_interrupt;
  logic [32*LANES-1:0] in_insn, in_addr;
  logic [4:0] in_ecause;
  logic [31:0] in_tval;
  logic out_valid, out_exception, out_interrupt, overflow;
  logic [31:0] out_insn, out_addr, out_tval;
  logic [4:0] out_ecause;
  logic [LW-1:0] level;
  logic [CNT_W-1:0] drop_cnt;

  always #5 clk = ~clk;

  trace_pkt_fifo #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_insn(in_insn),
    .in_addr(in_addr), .in_exception(in_exception), .in_interrupt(in_interrupt),
    .in_ecause(in_ecause), .in_tval(in_tval), .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_addr(out_addr), .out_exception(out_exception),
    .out_interrupt(out_interrupt), .out_ecause(out_ecause), .out_tval(out_tval),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .clr_status(clr_status)
  );

  typedef struct {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
  } rec_t;

  rec_t q[$];
  logic m_ovf;
  int   m_cnt;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference: a FIFO of records plus sticky status, advanced once per clock.
  task automatic model_step();
    int n;
    bit acc;
    int base;
    rec_t r;
    n = $countones(in_valid);
    if (flush) begin
      q.delete();
      if (clr_status) begin m_ovf = 1'b0; m_cnt = 0; end
    end else begin
      acc  = (n <= DEPTH - q.size());
      base = clr_status ? 0 : m_cnt;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (!acc) begin
        m_ovf = 1'b1;
        m_cnt = (base + n > CMAX) ? CMAX : base + n;
      end else begin
        if (clr_status) begin m_ovf = 1'b0; m_cnt = 0; end
        for (int i = 0; i < LANES; i++) begin
          if (in_valid[i]) begin
            r.insn   = in_insn[32*i +: 32];
            r.addr   = in_addr[32*i +: 32];
            r.exc    = in_exception[i];
            r.intr   = in_interrupt[i];
            r.ecause = (r.exc || r.intr) ? in_ecause : 5'd0;
            r.tval   = (r.exc || r.intr) ? in_tval : 32'd0;
            q.push_back(r);
          end
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; clr_status = 1'b0; in_valid = '0;
    in_exception = '0; in_interrupt = '0; in_ecause = '0; in_tval = '0;
  endtask

  task automatic set_lane(input int i, input logic [31:0] insn, input logic [31:0] addr);
    in_insn[32*i +: 32] = insn;
    in_addr[32*i +: 32] = addr;
  endtask

  task automatic push_groups(input int groups, input logic [LANES-1:0] v);
    for (int g = 0; g < groups; g++) begin
      in_valid = v;
      for (int i = 0; i < LANES; i++) set_lane(i, $urandom, $urandom);
      cycle();
    end
    in_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); out_ready = 1'b0; in_insn = '0; in_addr = '0;
    m_ovf = 1'b0; m_cnt = 0; q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    n_cmp++; if (drop_cnt !== '0) begin n_err++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    cycle();
    n_cmp++; if (out_valid !== 1'b0 || level !== '0) begin n_err++; $display("FAIL idle: valid %0b level %0d expected 0 0", out_valid, level); end
  endtask

  task automatic test_compaction();
    out_ready = 1'b1; in_valid = 3'b101;
    set_lane(0, 32'h1111_0000, 32'h100);
    set_lane(1, 32'h2222_0000, 32'h104);
    set_lane(2, 32'h3333_0000, 32'h108);
    cycle();
    in_valid = '0;
    n_cmp++; if (level !== 5'd2) begin n_err++; $display("FAIL cmp_level2: got %0d expected 2", level); end
    n_cmp++; if (out_valid !== 1'b1 || out_addr !== 32'h100) begin n_err++; $display("FAIL cmp_head0: valid %0b addr %h expected 1 100", out_valid, out_addr); end
    cycle();
    n_cmp++; if (level !== 5'd1) begin n_err++; $display("FAIL cmp_level1: got %0d expected 1", level); end
    n_cmp++; if (out_addr !== 32'h108 || out_insn !== 32'h3333_0000) begin n_err++; $display("FAIL cmp_head1: addr %h insn %h expected 108 33330000", out_addr, out_insn); end
    cycle();
    n_cmp++; if (level !== 5'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL cmp_empty: level %0d valid %0b expected 0 0", level, out_valid); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    push_groups(5, 3'b111);
    n_cmp++; if (level !== 5'd15) begin n_err++; $display("FAIL ovf_level15: got %0d expected 15", level); end
    push_groups(1, 3'b011);
    n_cmp++; if (level !== 5'd15) begin n_err++; $display("FAIL ovf_drop_level: got %0d expected 15", level); end
    n_cmp++; if (overflow !== 1'b1 || drop_cnt !== 5'd2) begin n_err++; $display("FAIL ovf_status: ovf %0b cnt %0d expected 1 2", overflow, drop_cnt); end
    push_groups(1, 3'b001);
    n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_full: got %0d expected 16", level); end
    push_groups(1, 3'b100);
    n_cmp++; if (level !== 5'd16 || drop_cnt !== 5'd3) begin n_err++; $display("FAIL ovf_full_drop: level %0d cnt %0d expected 16 3", level, drop_cnt); end
    out_ready = 1'b1;
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_addr !== q[0].addr) begin n_err++; $display("FAIL ovf_drain: valid %0b addr %h expected 1 %h", out_valid, out_addr, q[0].addr); end
      cycle();
    end
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL ovf_drained: got %0d expected 0", level); end
  endtask

  task automatic test_wrap();
    logic [31:0] w [3];
    flush = 1'b1; cycle(); flush = 1'b0;
    out_ready = 1'b0;
    push_groups(4, 3'b111);
    push_groups(1, 3'b011);
    out_ready = 1'b1;
    repeat (14) cycle();
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL wrap_pre: got %0d expected 0", level); end
    out_ready = 1'b0; in_valid = 3'b111;
    for (int i = 0; i < LANES; i++) begin w[i] = $urandom; set_lane(i, w[i], 32'h2000 + 4 * i); end
    cycle();
    in_valid = '0; out_ready = 1'b1;
    n_cmp++; if (level !== 5'd3) begin n_err++; $display("FAIL wrap_level: got %0d expected 3", level); end
    for (int i = 0; i < LANES; i++) begin
      n_cmp++; if (out_insn !== w[i] || out_addr !== 32'h2000 + 4 * i) begin n_err++; $display("FAIL wrap_order%0d: insn %h addr %h expected %h %h", i, out_insn, out_addr, w[i], 32'h2000 + 4 * i); end
      cycle();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty: got %0b expected 0", out_valid); end
  endtask

  task automatic test_exception();
    logic [31:0] t;
    out_ready = 1'b0; in_valid = 3'b111;
    for (int i = 0; i < LANES; i++) set_lane(i, 32'hA0 + i, 32'h300 + 4 * i);
    in_exception = 3'b010; in_ecause = 5'd2; in_tval = 32'hDEAD;
    cycle();
    idle_inputs(); out_ready = 1'b1;
    n_cmp++; if (out_exception !== 1'b0 || out_ecause !== 5'd0 || out_tval !== 32'd0) begin n_err++; $display("FAIL exc_lane0: exc %0b ecause %0d tval %h expected 0 0 0", out_exception, out_ecause, out_tval); end
    cycle();
    n_cmp++; if (out_exception !== 1'b1 || out_ecause !== 5'd2 || out_tval !== 32'hDEAD || out_insn !== 32'hA1) begin n_err++; $display("FAIL exc_lane1: exc %0b ecause %0d tval %h insn %h expected 1 2 dead a1", out_exception, out_ecause, out_tval, out_insn); end
    cycle();
    n_cmp++; if (out_exception !== 1'b0 || out_ecause !== 5'd0 || out_tval !== 32'd0) begin n_err++; $display("FAIL exc_lane2: exc %0b ecause %0d tval %h expected 0 0 0", out_exception, out_ecause, out_tval); end
    cycle();
    t = $urandom;
    out_ready = 1'b0; in_valid = 3'b001; in_interrupt = 3'b001; in_ecause = 5'd7; in_tval = t;
    cycle();
    idle_inputs();
    n_cmp++; if (out_interrupt !== 1'b1 || out_exception !== 1'b0 || out_ecause !== 5'd7 || out_tval !== t) begin n_err++; $display("FAIL int_lane0: int %0b exc %0b ecause %0d tval %h expected 1 0 7 %h", out_interrupt, out_exception, out_ecause, out_tval, t); end
    out_ready = 1'b1; cycle();
  endtask

  task automatic test_drop_clr_flush();
    out_ready = 1'b0;
    push_groups(5, 3'b111);
    push_groups(1, 3'b001);
    clr_status = 1'b1;
    push_groups(1, 3'b011);
    clr_status = 1'b0;
    n_cmp++; if (overflow !== 1'b1 || drop_cnt !== 5'd2) begin n_err++; $display("FAIL drop_and_clr: ovf %0b cnt %0d expected 1 2", overflow, drop_cnt); end
    flush = 1'b1; out_ready = 1'b1;
    push_groups(1, 3'b111);
    flush = 1'b0;
    n_cmp++; if (level !== 5'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_level: level %0d valid %0b expected 0 0", level, out_valid); end
    n_cmp++; if (drop_cnt !== 5'd2 || overflow !== 1'b1) begin n_err++; $display("FAIL flush_status: cnt %0d ovf %0b expected 2 1", drop_cnt, overflow); end
    clr_status = 1'b1; cycle(); clr_status = 1'b0;
    n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 5'd0) begin n_err++; $display("FAIL clr: ovf %0b cnt %0d expected 0 0", overflow, drop_cnt); end
    out_ready = 1'b0;
    push_groups(5, 3'b111);
    push_groups(1, 3'b001);
    cycle();
    n_cmp++; if (overflow !== 1'b0 || level !== 5'd16) begin n_err++; $display("FAIL empty_group: ovf %0b level %0d expected 0 16", overflow, level); end
    push_groups(12, 3'b111);
    n_cmp++; if (drop_cnt !== 5'd31 || overflow !== 1'b1) begin n_err++; $display("FAIL saturate: cnt %0d ovf %0b expected 31 1", drop_cnt, overflow); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || level !== '0) begin n_err++; $display("FAIL async_rst_fifo: valid %0b level %0d expected 0 0", out_valid, level); end
    n_cmp++; if (overflow !== 1'b0 || drop_cnt !== '0) begin n_err++; $display("FAIL async_rst_status: ovf %0b cnt %0d expected 0 0", overflow, drop_cnt); end
    q.delete(); m_ovf = 1'b0; m_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      in_valid     = LANES'($urandom);
      in_exception = ($urandom_range(0, 7) == 0) ? LANES'($urandom) : '0;
      in_interrupt = ($urandom_range(0, 9) == 0) ? LANES'($urandom) : '0;
      in_ecause    = 5'($urandom);
      in_tval      = $urandom;
      for (int i = 0; i < LANES; i++) set_lane(i, $urandom, $urandom);
      out_ready    = ($urandom_range(0, 99) < 55);
      flush        = ($urandom_range(0, 99) < 2);
      clr_status   = ($urandom_range(0, 199) < 1);
      cycle();
      n_cmp++; if (out_valid !== (q.size() != 0) || level !== LW'(q.size())) begin n_err++; $display("FAIL rnd_occ c=%0d: valid %0b level %0d expected %0b %0d", c, out_valid, level, q.size() != 0, q.size()); end
      n_cmp++; if (overflow !== m_ovf || drop_cnt !== CNT_W'(m_cnt)) begin n_err++; $display("FAIL rnd_status c=%0d: ovf %0b cnt %0d expected %0b %0d", c, overflow, drop_cnt, m_ovf, m_cnt); end
      if (q.size() != 0) begin
        n_cmp++;
        if (out_insn !== q[0].insn || out_addr !== q[0].addr || out_exception !== q[0].exc ||
            out_interrupt !== q[0].intr || out_ecause !== q[0].ecause || out_tval !== q[0].tval) begin
          n_err++;
          $display("FAIL rnd_head c=%0d: got %h %h %b %b %0d %h expected %h %h %b %b %0d %h", c,
                   out_insn, out_addr, out_exception, out_interrupt, out_ecause, out_tval,
                   q[0].insn, q[0].addr, q[0].exc, q[0].intr, q[0].ecause, q[0].tval);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_compaction();
    test_overflow();
    test_wrap();
    test_exception();
    test_drop_clr_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/trace_pkt_fifo.md
Name: trace_pkt_fifo

Overview:
Parametrised retire-trace buffer that generalises the fixed 3-lane trace packet to LANES lanes. Each cycle it accepts up to LANES retired-instruction records and compacts the valid lanes, in lane order, into a DEPTH-entry FIFO. It drains one record per cycle over a valid/ready interface to an external trace encoder or debug port. Sits between the decode/TLU trace outputs and the trace sink. Overflow drops whole retire groups and is reported through sticky status.

Parameters:
LANES, 3, retire lanes per cycle; 1..4
DEPTH, 16, FIFO entries; power of 2, >= LANES
CNT_W, 16, width of saturating drop counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous FIFO clear
in_valid  in  LANES  per-lane retire valid; lane 0 is oldest
in_insn  in  32*LANES  lane i instruction at [32i+31:32i]
in_addr  in  32*LANES  lane i PC at [32i+31:32i]
in_exception  in  LANES  per-lane exception flag
in_interrupt  in  LANES  per-lane interrupt flag
in_ecause  in  5  cause, shared by the group
in_tval  in  32  tval, shared by the group
out_valid  out  1  head record available
out_ready  in  1  sink accepts head record
out_insn  out  32  head instruction
out_addr  out  32  head PC
out_exception  out  1  head exception flag
out_interrupt  out  1  head interrupt flag
out_ecause  out  5  head cause; 0 unless exception or interrupt is set
out_tval  out  32  head tval; 0 unless exception or interrupt is set
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: at least one group dropped
drop_cnt  out  CNT_W  saturating count of dropped instructions
clr_status  in  1  clears overflow and drop_cnt

Behaviour:
- Reset (rst=1, asynchronous): pointers 0, level=0, out_valid=0, overflow=0, drop_cnt=0. Data outputs are don't-care while out_valid=0.
- Storage: write and read pointers are $clog2(DEPTH)+1 bits, with the MSB used as the wrap bit.
  - empty when the pointers are equal.
  - level = wr_ptr - rd_ptr (modulo arithmetic across wrap).
- Push:
  - n = popcount(in_valid).
  - The group is accepted iff n <= DEPTH - level, where level is the value before this cycle's pop. Same-cycle pop is not credited.
  - On accept, the valid lanes are written in ascending lane order to wr_ptr, wr_ptr+1, ... (compaction, so holes are skipped), then wr_ptr += n.
  - Per entry: store ecause/tval if that lane's exception or interrupt flag is set; otherwise store 0.
- Drop: if n > DEPTH - level, no lane of the group is written. overflow is set to 1, and drop_cnt += n, saturating at 2^CNT_W-1. A group is never split.
- Pop: when out_valid & out_ready, rd_ptr += 1.
  - out_* is driven combinationally from the entry at rd_ptr. out_valid = !empty.
  - Output holds stable while out_valid & !out_ready.
- Latency: a record pushed in cycle N can first appear on out_valid in cycle N+1. There is no write-to-read bypass.
- Simultaneous push and pop: both take effect. level(next) = level + n_accepted - pop.
- flush:
  - Both pointers go to 0 the next cycle, so out_valid=0 and level=0.
  - Any same-cycle push or pop is ignored.
  - A group discarded by flush is not counted as a drop.
  - flush does not touch overflow or drop_cnt.
- clr_status: clears overflow and drop_cnt. If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_cnt=n.
- n=0: no write. A group with no valid lanes is never a drop.
- Wrap-around: a compacted group may straddle entry DEPTH-1 to entry 0. Ordering must be preserved across the wrap.
- Reset asserted mid-operation discards all contents immediately (asynchronous).

Test Plan:
- Reset then idle -> out_valid=0, level=0, overflow=0, drop_cnt=0.
- LANES=3, in_valid=3'b101 with addr lanes {0x100, 0x104, 0x108}, out_ready=1 -> next cycle out_addr=0x100, then the following cycle 0x108. level goes 0->2->1->0.
- DEPTH=16, out_ready=0: push 5 groups of 3 (level=15), then a group in_valid=3'b011 -> dropped; overflow=1, drop_cnt=2, level=15. A subsequent single-lane group is accepted -> level=16.
- Pointer wrap: pre-fill and drain to rd_ptr=wr_ptr=14, push a 3-lane group -> entries 14, 15, 0. Drain yields lane0, lane1, lane2 in order, with out_insn matching the inputs.
- Lane1 in_exception=1, in_ecause=5'd2, in_tval=0xDEAD -> lane1's record shows exception=1, ecause=2, tval=0xDEAD; lanes 0 and 2 show ecause=0, tval=0.
- Same cycle: drop and clr_status together -> overflow=1, drop_cnt=n. Same cycle: flush and valid push -> level=0, drop_cnt unchanged.
